nmr_bstrm_simp_decode: RTL and testbench

Receive-side counterpart of the simple bitstream datapath: samples a single asynchronous bitstream line, measures the length of each constant-level run in CLK cycles, and emits one (length, polarity) record per completed run through a valid/ready handshake. Used for loopback verification of the pulse generator and for capturing external gate/trigger timing in the NMR front end.

---
 rtl/nmr_bstrm_pkg.sv | 18 +
 rtl/nmr_bstrm_sync.sv | 20 ++
 rtl/nmr_bstrm_simp_decode.sv | 125 ++++++++++++
 tb/tb_nmr_bstrm_simp_decode.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_bstrm_pkg.sv
// Shared types for the simple bitstream run-length decoder.
package nmr_bstrm_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] len;
    logic                      pol;
    logic                      sat;
  } rec_t;

endpackage

// File: rtl/nmr_bstrm_sync.sv
// Multi-flop synchronizer for a single asynchronous line.
module nmr_bstrm_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (RST) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/nmr_bstrm_simp_decode.sv
// Bitstream run-length decoder: measures each constant-level run of IN and
// emits one (length, polarity, saturated) record per completed run.
module nmr_bstrm_simp_decode
  import nmr_bstrm_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  IN,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  PLS_POL,
  output logic                  VALID,
  input  logic                  READY,
  output logic                  LEN_SAT,
  output logic                  OVF,
  output logic                  ARMED
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] len;
    logic                  pol;
    logic                  sat;
  } rec_p_t;

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = 1;

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic                  r_sat;
  logic                  r_prev;
  logic                  r_valid;
  logic                  r_ovf;
  rec_p_t                r_rec;

  logic                  w_s_in;
  logic                  w_edge;
  logic                  w_emit;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_cnt_inc;

  nmr_bstrm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .i_d (IN),
    .o_q (w_s_in)
  );

  assign w_edge    = (w_s_in != r_prev);
  // Only edges that close a fully observed run produce a record.
  assign w_emit    = (r_state == COUNT) && EN && w_edge;
  assign w_load    = !r_valid || READY;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_prev  <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_rec   <= '0;
    end else begin
      r_prev <= w_s_in;

      case (r_state)
        IDLE: begin
          if (EN) begin
            r_state <= ARM;
            r_ovf   <= 1'b0;
          end
        end
        ARM: begin
          if (!EN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
          end else if (w_edge) begin
            r_state <= COUNT;
            r_cnt   <= CNT_ONE;
            r_sat   <= 1'b0;
          end
        end
        COUNT: begin
          if (!EN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
          end else if (w_edge) begin
            r_cnt <= CNT_ONE;
            r_sat <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            r_sat <= (w_cnt_inc == CNT_MAX);
          end
        end
        default: r_state <= IDLE;
      endcase

      // Single-entry output slot: a record arriving while it is still full is lost.
      if (w_emit) begin
        if (w_load) begin
          r_rec   <= '{len: r_cnt, pol: r_prev, sat: r_sat};
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && READY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data    = r_rec.len;
  assign PLS_POL = r_rec.pol;
  assign LEN_SAT = r_rec.sat;
  assign VALID   = r_valid;
  assign OVF     = r_ovf;
  assign ARMED   = (r_state != IDLE);

endmodule

// File: tb/tb_nmr_bstrm_simp_decode.sv
// Directed bench for the run-length decoder, built with a 4-bit length field.
module tb_nmr_bstrm_simp_decode;

  localparam int DW = 4;

  logic          CLK = 1'b0;
  logic          RST, EN, IN, READY;
  logic [DW-1:0] data;
  logic          PLS_POL, VALID, LEN_SAT, OVF, ARMED;

  int errors = 0;
  int checks = 0;
  int n_valid;
  logic [DW-1:0] q_len[$];
  logic          q_pol[$];
  logic          q_sat[$];

  always #5 CLK = ~CLK;

  nmr_bstrm_simp_decode #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .IN      (IN),
    .data    (data),
    .PLS_POL (PLS_POL),
    .VALID   (VALID),
    .READY   (READY),
    .LEN_SAT (LEN_SAT),
    .OVF     (OVF),
    .ARMED   (ARMED)
  );

  task automatic step();
    @(posedge CLK);
    #1;
    if (VALID) begin
      n_valid++;
      if (READY) begin
        q_len.push_back(data);
        q_pol.push_back(PLS_POL);
        q_sat.push_back(LEN_SAT);
      end
    end
  endtask

  task automatic run(input logic lvl, input int n);
    repeat (n) begin
      IN = lvl;
      step();
    end
  endtask

  task automatic clear_log();
    n_valid = 0;
    q_len.delete();
    q_pol.delete();
    q_sat.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; IN = 1'b0; READY = 1'b0;
    step();
    step();
    RST = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({data, PLS_POL, VALID, LEN_SAT, OVF, ARMED} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%0d pol=%b valid=%b sat=%b ovf=%b armed=%b, want all 0",
               data, PLS_POL, VALID, LEN_SAT, OVF, ARMED);
    end
  endtask

  task automatic test_basic();
    do_reset();
    EN = 1'b1; READY = 1'b1;
    step();
    checks++;
    if (ARMED !== 1'b1) begin errors++; $display("FAIL basic_armed: got %b want 1", ARMED); end
    clear_log();
    run(1'b1, 4); run(1'b0, 5); run(1'b1, 6);
    checks++;
    if (q_len.size() !== 2) begin
      errors++; $display("FAIL basic_count: got %0d records want 2", q_len.size());
    end else begin
      checks++;
      if ({q_len[0], q_pol[0], q_sat[0]} !== {4'd4, 1'b1, 1'b0}) begin
        errors++; $display("FAIL basic_rec0: got (%0d,%b,%b) want (4,1,0)", q_len[0], q_pol[0], q_sat[0]);
      end
      checks++;
      if ({q_len[1], q_pol[1], q_sat[1]} !== {4'd5, 1'b0, 1'b0}) begin
        errors++; $display("FAIL basic_rec1: got (%0d,%b,%b) want (5,0,0)", q_len[1], q_pol[1], q_sat[1]);
      end
    end
    checks++;
    if (n_valid !== 2) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 2", n_valid); end
    checks++;
    if (OVF !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", OVF); end
  endtask

  task automatic test_backpressure();
    do_reset();
    EN = 1'b1; READY = 1'b0;
    run(1'b0, 2); run(1'b1, 3); run(1'b0, 7); run(1'b1, 4);
    checks++;
    if ({VALID, data, PLS_POL, OVF} !== {1'b1, 4'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL bp_held: got valid=%b data=%0d pol=%b ovf=%b want valid=1 data=3 pol=1 ovf=1",
               VALID, data, PLS_POL, OVF);
    end
    READY = 1'b1;
    step();
    checks++;
    if (VALID !== 1'b0) begin errors++; $display("FAIL bp_consume: got valid=%b want 0", VALID); end
    checks++;
    if (OVF !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b want 1", OVF); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    EN = 1'b1; READY = 1'b1;
    run(1'b0, 2);
    clear_log();
    for (int i = 0; i < 10; i++) run((i % 2 == 0) ? 1'b1 : 1'b0, 1);
    run(1'b0, 4);
    checks++;
    if (q_len.size() !== 9) begin
      errors++; $display("FAIL b2b_count: got %0d records want 9", q_len.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if ({q_len[i], q_pol[i]} !== {4'd1, (i % 2 == 0) ? 1'b1 : 1'b0}) begin
          errors++;
          $display("FAIL b2b_rec%0d: got (%0d,%b) want (1,%b)", i, q_len[i], q_pol[i], (i % 2 == 0));
        end
      end
    end
    checks++;
    if (n_valid !== 9) begin errors++; $display("FAIL b2b_valid_cycles: got %0d want 9", n_valid); end
    checks++;
    if (OVF !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", OVF); end
  endtask

  task automatic test_saturation();
    do_reset();
    EN = 1'b1; READY = 1'b1;
    run(1'b0, 2);
    clear_log();
    run(1'b1, 20); run(1'b0, 4);
    checks++;
    if (q_len.size() !== 1) begin
      errors++; $display("FAIL sat_count: got %0d records want 1", q_len.size());
    end else begin
      checks++;
      if ({q_len[0], q_pol[0], q_sat[0]} !== {4'd15, 1'b1, 1'b1}) begin
        errors++; $display("FAIL sat_rec: got (%0d,%b,%b) want (15,1,1)", q_len[0], q_pol[0], q_sat[0]);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    EN = 1'b1; READY = 1'b0;
    run(1'b0, 2); run(1'b1, 3); run(1'b0, 3); run(1'b1, 4);
    checks++;
    if ({VALID, data, OVF} !== {1'b1, 4'd3, 1'b1}) begin
      errors++; $display("FAIL en_setup: got valid=%b data=%0d ovf=%b want 1,3,1", VALID, data, OVF);
    end
    EN = 1'b0;
    step();
    checks++;
    if ({ARMED, VALID, data} !== {1'b0, 1'b1, 4'd3}) begin
      errors++; $display("FAIL en_drop_pending: got armed=%b valid=%b data=%0d want 0,1,3", ARMED, VALID, data);
    end
    READY = 1'b1;
    step();
    checks++;
    if (VALID !== 1'b0) begin errors++; $display("FAIL en_consume: got valid=%b want 0", VALID); end
    clear_log();
    run(1'b0, 1); run(1'b1, 1); run(1'b0, 1); run(1'b1, 1); run(1'b0, 4);
    checks++;
    if ({n_valid != 0, ARMED, OVF} !== {1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL en_disabled: got valid_cycles=%0d armed=%b ovf=%b want 0,0,1", n_valid, ARMED, OVF);
    end
    EN = 1'b1;
    step();
    checks++;
    if ({ARMED, OVF} !== {1'b1, 1'b0}) begin
      errors++; $display("FAIL en_rearm: got armed=%b ovf=%b want 1,0", ARMED, OVF);
    end
    clear_log();
    run(1'b0, 2); run(1'b1, 4); run(1'b0, 4);
    checks++;
    if (q_len.size() !== 1) begin
      errors++; $display("FAIL en_rearm_count: got %0d records want 1", q_len.size());
    end else begin
      checks++;
      if ({q_len[0], q_pol[0]} !== {4'd4, 1'b1}) begin
        errors++; $display("FAIL en_rearm_rec: got (%0d,%b) want (4,1)", q_len[0], q_pol[0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    EN = 1'b1; READY = 1'b0;
    run(1'b0, 2); run(1'b1, 3); run(1'b0, 4);
    checks++;
    if ({VALID, ARMED} !== 2'b11) begin
      errors++; $display("FAIL rst_setup: got valid=%b armed=%b want 1,1", VALID, ARMED);
    end
    RST = 1'b1;
    step();
    checks++;
    if ({data, PLS_POL, VALID, LEN_SAT, OVF, ARMED} !== '0) begin
      errors++;
      $display("FAIL rst_midrun: got data=%0d pol=%b valid=%b sat=%b ovf=%b armed=%b, want all 0",
               data, PLS_POL, VALID, LEN_SAT, OVF, ARMED);
    end
    RST = 1'b0; EN = 1'b0;
    clear_log();
    run(1'b0, 3);
    checks++;
    if (n_valid !== 0) begin errors++; $display("FAIL rst_no_record: got %0d valid cycles want 0", n_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_enable();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
